// File: rtl/bitserial_gate_sequencer.sv
// Bit-serial gate sequencer: one shared 1-bit NAND-built gate cell is applied
// to a captured WIDTH-bit operand pair, one bit per cycle, LSB first.
// The assembled result is published to `out` only when the last bit completes.
module bitserial_gate_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned   IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic bit_a, bit_b;
  logic n_ab, n_a, n_b, or_ab, x_l, x_r;
  logic gate_bit;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  // Shared gate cell: every function is composed from 2-input NANDs; ops 6/7 yield 0.
  always_comb begin
    n_ab  = nand2(bit_a, bit_b);
    n_a   = nand2(bit_a, bit_a);
    n_b   = nand2(bit_b, bit_b);
    or_ab = nand2(n_a, n_b);
    x_l   = nand2(bit_a, n_ab);
    x_r   = nand2(bit_b, n_ab);
    case (op_q)
      3'd0:    gate_bit = nand2(n_ab, n_ab);
      3'd1:    gate_bit = or_ab;
      3'd2:    gate_bit = n_a;
      3'd3:    gate_bit = nand2(or_ab, or_ab);
      3'd4:    gate_bit = nand2(x_l, x_r);
      3'd5:    gate_bit = n_ab;
      default: gate_bit = 1'b0;
    endcase
  end

  // Next-state, operand capture, bit assembly and status outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        busy         = 1'b1;
        acc_d[idx_q] = gate_bit;
        if (idx_q == LAST) begin
          // publish the full word on the same edge the last bit lands
          state_d = S_DONE;
          out_d   = acc_d;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = op_q[2] & op_q[1];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule
